// File: rtl/i281_imem_pkg.sv
// Shared types and sizing for the instruction-memory download sequencer.
package i281_imem_pkg;

    localparam int unsigned DATA_W         = 16;
    localparam int unsigned WORDS_PER_BANK = 16;
    localparam int unsigned NUM_BANKS      = 2;
    localparam int unsigned SEL_W          = $clog2(WORDS_PER_BANK);
    localparam int unsigned ADDR_W         = $clog2(WORDS_PER_BANK * NUM_BANKS);

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS_PER_BANK * NUM_BANKS - 1);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_LOAD  = 2'd2,
        ST_FLUSH = 2'd3
    } imem_state_e;

    // One bank write as presented to both register files
    typedef struct packed {
        logic              we_high;
        logic              we_low;
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] data;
    } imem_wr_t;

endpackage

// File: rtl/imem_word_counter.sv
// Download word counter: sync clear, enable, saturates at the last word of the high bank.
module imem_word_counter
    import i281_imem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    output logic [ADDR_W-1:0] count,
    output logic              last_word_c
);

    assign last_word_c = (count == LAST_WORD);

    // Holding at LAST_WORD keeps the final download from wrapping the count to zero
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && !last_word_c) begin
            count <= count + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/imem_load_sequencer.sv
// Sequences BIOS preload and streamed program download into the low/high IMEM banks,
// stalling CPU fetch while either is in progress.
module imem_load_sequencer
    import i281_imem_pkg::*;
(
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              LOAD_START,
    input  logic              LOAD_ABORT,
    input  logic              IN_VALID,
    input  logic [DATA_W-1:0] IN_DATA,
    output logic              IN_READY,
    output logic [SEL_W-1:0]  WRITE_SELECT,
    output logic [DATA_W-1:0] IMEM_INPUT,
    output logic              WE_LOW,
    output logic              WE_HIGH,
    output logic              CPU_STALL,
    output logic              LOAD_DONE,
    output logic [ADDR_W-1:0] WORD_COUNT
);

    imem_state_e state_q, state_d;
    imem_wr_t    wr_q, wr_d;
    logic        load_done_d;
    logic        stall_d;
    logic        cnt_clr;
    logic        cnt_en;
    logic        last_word_c;

    imem_word_counter u_word_counter (
        .clk         (CLOCK),
        .rst         (RESET),
        .clr         (cnt_clr),
        .en          (cnt_en),
        .count       (WORD_COUNT),
        .last_word_c (last_word_c)
    );

    // Ready depends on state only so the loader never sees a combinational loop
    assign IN_READY = (state_q == ST_LOAD);

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus next values of the registered write/status outputs
    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        wr_d.we_low = 1'b0;
        wr_d.we_high = 1'b0;
        load_done_d = 1'b0;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;

        case (state_q)
            ST_INIT: begin
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (LOAD_START) begin
                    state_d = ST_LOAD;
                    cnt_clr = 1'b1;
                end
            end
            ST_LOAD: begin
                // Abort takes priority over a word offered in the same cycle
                if (LOAD_ABORT) begin
                    state_d = ST_IDLE;
                end else if (IN_VALID) begin
                    wr_d.sel     = WORD_COUNT[SEL_W-1:0];
                    wr_d.data    = IN_DATA;
                    wr_d.we_low  = ~WORD_COUNT[ADDR_W-1];
                    wr_d.we_high = WORD_COUNT[ADDR_W-1];
                    cnt_en       = 1'b1;
                    if (last_word_c) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                state_d     = ST_IDLE;
                load_done_d = 1'b1;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        stall_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            wr_q      <= '0;
            LOAD_DONE <= 1'b0;
            CPU_STALL <= 1'b1;
        end else begin
            wr_q      <= wr_d;
            LOAD_DONE <= load_done_d;
            CPU_STALL <= stall_d;
        end
    end

    assign WRITE_SELECT = wr_q.sel;
    assign IMEM_INPUT   = wr_q.data;
    assign WE_LOW       = wr_q.we_low;
    assign WE_HIGH      = wr_q.we_high;

endmodule

// File: tb/tb_imem_load_sequencer.sv
// Scoreboard bench for imem_load_sequencer: directed downloads, abort, reset and ignored controls.
module tb_imem_load_sequencer;

    logic        clk;
    logic        rst;
    logic        load_start;
    logic        load_abort;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic [3:0]  write_select;
    logic [15:0] imem_input;
    logic        we_low;
    logic        we_high;
    logic        cpu_stall;
    logic        load_done;
    logic [4:0]  word_count;

    int          checks;
    int          failures;
    int          done_pulses;
    logic [4:0]  exp_cnt;
    logic [20:0] exp_q[$];
    logic [15:0] bank_lo[16];
    logic [15:0] bank_hi[16];

    imem_load_sequencer dut (
        .CLOCK        (clk),
        .RESET        (rst),
        .LOAD_START   (load_start),
        .LOAD_ABORT   (load_abort),
        .IN_VALID     (in_valid),
        .IN_DATA      (in_data),
        .IN_READY     (in_ready),
        .WRITE_SELECT (write_select),
        .IMEM_INPUT   (imem_input),
        .WE_LOW       (we_low),
        .WE_HIGH      (we_high),
        .CPU_STALL    (cpu_stall),
        .LOAD_DONE    (load_done),
        .WORD_COUNT   (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] bios(input bit hi, input int i);
        return 16'(32'h1000 + (hi ? 16 : 0) + i);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one word while in LOAD and record the bank write it must produce
    task automatic drive_word(input logic [15:0] data);
        in_valid = 1'b1;
        in_data  = data;
        exp_q.push_back({exp_cnt[4], exp_cnt[3:0], data});
        if (exp_cnt != 5'd31) exp_cnt = exp_cnt + 5'd1;
        step();
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        step();
    endtask

    task automatic start_load();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        exp_cnt    = 5'd0;
    endtask

    task automatic reset_dut();
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        exp_q.delete();
        exp_cnt = 5'd0;
        step();
    endtask

    // Behavioural IMEM banks: BIOS image while in reset, otherwise follow the write strobes
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                bank_lo[i] <= bios(1'b0, i);
                bank_hi[i] <= bios(1'b1, i);
            end
        end else begin
            if (we_low)  bank_lo[write_select] <= imem_input;
            if (we_high) bank_hi[write_select] <= imem_input;
        end
    end

    // Monitor: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        logic [20:0] e;
        if (we_low || we_high) begin
            chk("we_exclusive", 32'(we_low & we_high), 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=%0h required=none",
                         {we_high, write_select, imem_input});
            end else begin
                e = exp_q.pop_front();
                chk("bank_write", 32'({we_high, write_select, imem_input}), 32'(e));
            end
        end
        if (load_done) done_pulses++;
    end

    initial begin
        checks      = 0;
        failures    = 0;
        done_pulses = 0;
        exp_cnt     = 5'd0;
        rst         = 1'b1;
        load_start  = 1'b0;
        load_abort  = 1'b0;
        in_valid    = 1'b0;
        in_data     = 16'h0;

        // Reset values, one INIT cycle, then IDLE with BIOS in the banks
        repeat (3) step();
        chk("rst_stall", 32'(cpu_stall), 32'd1);
        chk("rst_we", 32'({we_low, we_high}), 32'd0);
        chk("rst_count", 32'(word_count), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_sel_data", 32'({write_select, imem_input}), 32'd0);
        rst = 1'b0;
        chk("init_stall", 32'(cpu_stall), 32'd1);
        step();
        chk("idle_stall", 32'(cpu_stall), 32'd0);
        chk("idle_ready", 32'(in_ready), 32'd0);
        chk("bios_lo3", 32'(bank_lo[3]), 32'(bios(1'b0, 3)));
        chk("bios_hi7", 32'(bank_hi[7]), 32'(bios(1'b1, 7)));

        // Full back-to-back download
        done_pulses = 0;
        start_load();
        chk("load_ready", 32'(in_ready), 32'd1);
        chk("load_stall", 32'(cpu_stall), 32'd1);
        chk("load_count0", 32'(word_count), 32'd0);
        for (int i = 0; i < 32; i++) drive_word(16'(32'hA000 + i));
        in_valid = 1'b0;
        chk("flush_ready", 32'(in_ready), 32'd0);
        chk("flush_stall", 32'(cpu_stall), 32'd1);
        chk("full_count", 32'(word_count), 32'd31);
        step();
        chk("done_pulse", 32'(load_done), 32'd1);
        chk("done_stall", 32'(cpu_stall), 32'd0);
        step();
        chk("done_clear", 32'(load_done), 32'd0);
        chk("done_once", 32'(done_pulses), 32'd1);
        chk("full_lo0", 32'(bank_lo[0]), 32'hA000);
        chk("full_lo5", 32'(bank_lo[5]), 32'hA005);
        chk("full_hi15", 32'(bank_hi[15]), 32'hA01F);
        chk("full_drained", 32'(exp_q.size()), 32'd0);

        // Gappy stream of 10 words, then abort with a word offered
        reset_dut();
        done_pulses = 0;
        start_load();
        for (int i = 0; i < 20; i++) begin
            if ((i % 2) == 0) drive_word(16'(32'hC000 + i / 2));
            else idle_cycle();
        end
        chk("gap_count", 32'(word_count), 32'd10);
        in_valid   = 1'b1;
        in_data    = 16'hBEEF;
        load_abort = 1'b1;
        step();
        load_abort = 1'b0;
        in_valid   = 1'b0;
        chk("abort_ready", 32'(in_ready), 32'd0);
        chk("abort_stall", 32'(cpu_stall), 32'd0);
        chk("abort_count", 32'(word_count), 32'd10);
        step();
        step();
        chk("abort_no_done", 32'(done_pulses), 32'd0);
        chk("abort_lo0", 32'(bank_lo[0]), 32'hC000);
        chk("abort_lo9", 32'(bank_lo[9]), 32'hC009);
        chk("abort_lo10", 32'(bank_lo[10]), 32'(bios(1'b0, 10)));
        chk("abort_hi0", 32'(bank_hi[0]), 32'(bios(1'b1, 0)));
        chk("abort_drained", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a download
        start_load();
        for (int i = 0; i < 20; i++) drive_word(16'(32'hD000 + i));
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'hD014;
        step();
        chk("midrst_stall", 32'(cpu_stall), 32'd1);
        chk("midrst_we", 32'({we_low, we_high}), 32'd0);
        chk("midrst_count", 32'(word_count), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd0);
        chk("midrst_sel_data", 32'({write_select, imem_input}), 32'd0);
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        exp_cnt = 5'd0;
        chk("midrst_init", 32'(cpu_stall), 32'd1);
        step();
        chk("midrst_idle", 32'(cpu_stall), 32'd0);
        chk("midrst_lo0", 32'(bank_lo[0]), 32'(bios(1'b0, 0)));
        chk("midrst_lo15", 32'(bank_lo[15]), 32'(bios(1'b0, 15)));

        // LOAD_START during LOAD and LOAD_ABORT during FLUSH are ignored
        done_pulses = 0;
        start_load();
        for (int i = 0; i < 32; i++) begin
            if (i == 5) load_start = 1'b1;
            drive_word(16'(32'hE000 + i));
            load_start = 1'b0;
        end
        in_valid   = 1'b0;
        load_abort = 1'b1;
        chk("flush2_ready", 32'(in_ready), 32'd0);
        step();
        load_abort = 1'b0;
        chk("flush2_done", 32'(load_done), 32'd1);
        step();
        step();
        chk("flush2_once", 32'(done_pulses), 32'd1);
        chk("flush2_stall", 32'(cpu_stall), 32'd0);
        chk("flush2_lo5", 32'(bank_lo[5]), 32'hE005);
        chk("flush2_hi15", 32'(bank_hi[15]), 32'hE01F);
        chk("flush2_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
